// File: rtl/demo_streaming_0_tick_sampler.sv
// demo_streaming_0_tick_sampler: captures a sample per timer tick into a FIFO drained over Avalon-MM
module demo_streaming_0_tick_sampler #(
   parameter int DEPTH = 16,
   parameter int AW = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        timer_irq,
   input  logic [15:0] sample_data,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        irq
);
   logic [15:0] mem_q [DEPTH];
   logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
   logic [AW:0] level_q, level_d, thr_q, thr_d;
   logic ovf_q, ovf_d, en_q, en_d, ien_q, ien_d, tirq_q, irq_q, irq_d;
   logic [31:0] tick_q, tick_d;
   logic [15:0] hold_q, hold_d, rdata_q, rdata_d, head;
   logic wr, rd, tick, full, not_empty, pop, try_push, push, flush, clr_tick, unused_ok;
   always_comb begin
      wr = chipselect & ~write_n;
      rd = chipselect & ~read_n;
      tick = timer_irq & ~tirq_q;
      full = level_q == (AW+1)'(DEPTH);
      not_empty = level_q != '0;
      pop = rd && address == 3'd2 && not_empty;
      try_push = tick & en_q;
      push = try_push & (~full | pop);
      flush = wr && address == 3'd1 && writedata[2];
      clr_tick = wr && (address == 3'd4 || address == 3'd5);
      level_d = flush ? '0 : level_q + (AW+1)'(push) - (AW+1)'(pop);
      wptr_d = flush ? '0 : wptr_q + AW'(push);
      rptr_d = flush ? '0 : rptr_q + AW'(pop);
      ovf_d = (flush || (wr && address == 3'd0)) ? 1'b0 : ovf_q | (try_push & ~push);
      en_d = (wr && address == 3'd1) ? writedata[0] : en_q;
      ien_d = (wr && address == 3'd1) ? writedata[1] : ien_q;
      thr_d = (wr && address == 3'd6) ? writedata[AW:0] : thr_q;
      tick_d = clr_tick ? '0 : tick_q + 32'(try_push);
      hold_d = clr_tick ? '0 : (rd && address == 3'd4) ? tick_q[31:16] : hold_q;
      head = not_empty ? mem_q[rptr_q] : '0;
      rdata_d = !rd ? '0 :
                address == 3'd0 ? {12'd0, full, en_q, ovf_q, not_empty} :
                address == 3'd1 ? {14'd0, ien_q, en_q} :
                address == 3'd2 ? head :
                address == 3'd3 ? 16'(level_q) :
                address == 3'd4 ? tick_q[15:0] :
                address == 3'd5 ? hold_q :
                address == 3'd6 ? 16'(thr_q) : '0;
      irq_d = ien_q & (ovf_q | (thr_q != '0 && level_q >= thr_q));
      unused_ok = ^writedata[15:AW+1];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         rptr_q <= '0;
         wptr_q <= '0;
         level_q <= '0;
         thr_q <= (AW+1)'(1);
         ovf_q <= 1'b0;
         en_q <= 1'b0;
         ien_q <= 1'b0;
         tirq_q <= 1'b0;
         irq_q <= 1'b0;
         tick_q <= '0;
         hold_q <= '0;
         rdata_q <= '0;
      end else begin
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         level_q <= level_d;
         thr_q <= thr_d;
         ovf_q <= ovf_d;
         en_q <= en_d;
         ien_q <= ien_d;
         tirq_q <= timer_irq;
         irq_q <= irq_d;
         tick_q <= tick_d;
         hold_q <= hold_d;
         rdata_q <= rdata_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push && !reset) mem_q[wptr_q] <= sample_data;
   end
   assign readdata = rdata_q;
   assign irq = irq_q;
endmodule

// File: doc/demo_streaming_0_tick_sampler.md
Name: demo_streaming_0_tick_sampler

Overview:
- Sits directly downstream of the streaming interval timer and consumes its `irq` output as a sampling tick.
- On each timer tick it captures a 16-bit streaming sample into a FIFO and counts the tick.
- Software drains samples over an Avalon-MM slave.
- Raises its own interrupt on a fill threshold or on overflow.

Parameters:
- DEPTH, 16, FIFO depth in words; power of two, 2..256.
- AW, 4, log2(DEPTH); the level register is AW+1 bits wide.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- timer_irq  in  1  level irq from the interval timer; stays high until the timer status is cleared
- sample_data  in  16  sample captured on a tick
- address  in  3  Avalon word address
- chipselect  in  1  Avalon select
- read_n  in  1  active-low read strobe
- write_n  in  1  active-low write strobe
- writedata  in  16  Avalon write data
- readdata  out  16  registered read data
- irq  out  1  level interrupt

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - readdata=0, irq=0.
  - FIFO empty, level=0, overflow=0.
  - enable=0, irq_enable=0, threshold=1.
  - tick_count=0, timer_irq_d=0.
- Strobes:
  - wr(a) = chipselect & ~write_n & (address==a).
  - rd(a) = chipselect & ~read_n & (address==a).
- Tick: tick = timer_irq & ~timer_irq_d, where timer_irq_d is registered every cycle. A held-high irq therefore yields exactly one tick.
- On tick with enable=1:
  - tick_count increments by 1, 32-bit, wraps 0xFFFFFFFF -> 0.
  - A push of sample_data (as sampled that same cycle) is attempted.
- With enable=0, ticks are ignored: no count, no push.
- Push accepted if level<DEPTH, or if a pop occurs in the same cycle. Otherwise the sample is dropped and overflow is set (sticky).
- Pop = rd(2) with level>0. rd(2) on an empty FIFO returns 0 and changes nothing.
- Simultaneous push and pop: level is unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Flush = wr(1) with writedata[2]=1:
  - Next cycle level=0, pointers=0, overflow=0.
  - Flush beats any push or pop in the same cycle.
  - Flush is not stored; it reads back as 0.
- Register map (readdata is registered, 1-cycle latency, updated every cycle; unmapped addresses read 0):
  - 0 STATUS (read): bit0 not_empty, bit1 overflow, bit2 enable, bit3 full. Any wr(0) clears overflow; this takes priority over an overflow-setting drop in the same cycle.
  - 1 CONTROL (read/write): bit0 enable, bit1 irq_enable, bit2 flush (write-only strobe).
  - 2 DATA (read): head word, sampled before the pop in that same cycle. Writes are ignored.
  - 3 LEVEL (read): zero-extended level.
  - 4 TICK_L, 5 TICK_H (read): tick_count halves.
    - rd(4) latches tick_count[31:16] into a holding register; rd(5) returns the holding register, giving a coherent 32-bit read.
    - Any write to 4 or 5 clears tick_count and the holding register.
  - 6 THRESHOLD (read/write): low AW+1 bits are stored; the upper bits read as 0.
- irq (registered) = irq_enable & (overflow | (threshold!=0 & level>=threshold)). It is updated the cycle after its inputs change.
- reset mid-stream: all state returns to reset values on the next edge. Contents of the FIFO storage array need not clear.

Test Plan:
- After reset, read addr 0/1/3/6 -> readdata 0x0000, 0x0000, 0x0000, 0x0001 one cycle after each rd; irq=0.
- enable=1; timer_irq high for 5 cycles with sample_data=0x1234 -> exactly one push; LEVEL=1, TICK_L=1; DATA read returns 0x1234, then LEVEL=0.
- 17 ticks with samples 0..16, DEPTH=16 -> LEVEL=16, STATUS=0x000F (not_empty, overflow, enable, full); 16 DATA reads return 0..15 in order; then wr(0) -> STATUS=0x0004.
- Tick coinciding with rd(2) while full -> LEVEL stays 16, no overflow; head advances by one.
- irq_enable=1, threshold=4 -> irq rises the cycle after LEVEL reaches 4; one pop -> irq low; threshold=0 -> irq only on overflow.
- Preload tick_count to 0xFFFF via 65535 ticks, then one more tick -> rd(4) returns 0x0000, rd(5) returns 0x0001. Flush and tick in the same cycle -> LEVEL=0, tick counted.
